// File: rtl/nn_lstm_bptt_seq_polar.sv
`default_nettype none
//==============================================================================
// Module   : nn_lstm_bptt_seq_polar
// Purpose  : Polar-stochastic LSTM BPTT gate-delta unit. It is sequenced over
//            time-step windows and carries the cell-state gradient between
//            steps as a signed estimate.
// Options  : define NN_LSTM_BPTT_CLIP_EN to clamp the stored estimate to +/-CLIP
// Revision : 1.0 - initial release
//==============================================================================
module nn_lstm_bptt_seq_polar #(
    parameter int N       = 3,
    parameter int NR      = 3,
    parameter int LOG_LEN = 8,
    parameter int ACC_W   = 4,
    parameter int CLIP    = 2 ** (LOG_LEN - 1)
) (
    input  logic               CLK,
    input  logic               INIT,
    input  logic               step_start,
    input  logic               step_first,
    input  logic [N-1:0]       delta_forwardLayer,
    input  logic [N-1:0]       SIGN_delta_forwardLayer,
    input  logic [N-1:0]       alpha,
    input  logic [N-1:0]       SIGN_alpha,
    input  logic [NR-1:0]      delta_c_next,
    input  logic [NR-1:0]      SIGN_delta_c_next,
    input  logic [NR-1:0]      delta_f_next,
    input  logic [NR-1:0]      SIGN_delta_f_next,
    input  logic [NR-1:0]      delta_i_next,
    input  logic [NR-1:0]      SIGN_delta_i_next,
    input  logic [NR-1:0]      delta_o_next,
    input  logic [NR-1:0]      SIGN_delta_o_next,
    input  logic [NR-1:0]      alpha_c_r,
    input  logic [NR-1:0]      SIGN_alpha_c_r,
    input  logic [NR-1:0]      alpha_f_r,
    input  logic [NR-1:0]      SIGN_alpha_f_r,
    input  logic [NR-1:0]      alpha_i_r,
    input  logic [NR-1:0]      SIGN_alpha_i_r,
    input  logic [NR-1:0]      alpha_o_r,
    input  logic [NR-1:0]      SIGN_alpha_o_r,
    input  logic               f,
    input  logic               i,
    input  logic               c,
    input  logic               o,
    input  logic               f_next,
    input  logic               STATE_last,
    input  logic               STATE_flat,
    input  logic               zp_f,
    input  logic               zp_i,
    input  logic               zp_o,
    input  logic               zp_c,
    input  logic [LOG_LEN-1:0] rnd,
    output logic               delta_f,
    output logic               delta_i,
    output logic               delta_c,
    output logic               delta_o,
    output logic               SIGN_delta_f,
    output logic               SIGN_delta_i,
    output logic               SIGN_delta_c,
    output logic               SIGN_delta_o,
    output logic               busy,
    output logic               step_done,
    output logic [LOG_LEN:0]   delta_state_est
);

    localparam int                C_ACC_MAX = 2 ** (ACC_W - 1) - 1;
    localparam int                C_CNT_MAX = 2 ** LOG_LEN - 1;
    localparam int                C_CNT_MIN = -(2 ** LOG_LEN);
    localparam logic [LOG_LEN+1:0] C_K_FIRST = (LOG_LEN + 2)'(3);
    localparam logic [LOG_LEN+1:0] C_K_LAST  = (LOG_LEN + 2)'(2 ** LOG_LEN + 2);

`ifdef NN_LSTM_BPTT_CLIP_EN
    localparam int C_EST_LIM = (CLIP < C_CNT_MAX) ? CLIP : C_CNT_MAX;
`else
    localparam int C_EST_LIM     = C_CNT_MAX;
    localparam int C_UNUSED_CLIP = CLIP;
`endif

    typedef struct packed {
        logic                    out;
        logic                    sgn;
        logic signed [ACC_W-1:0] acc;
    } add_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed contribution of one polar product term.
    function automatic int polar_term(input logic mag, input logic sgn);
        return mag ? (sgn ? -1 : 1) : 0;
    endfunction

    function automatic add_t polar_add(input logic signed [ACC_W-1:0] acc, input int diff);
        int   a;
        add_t r;
        r = '0;
        a = int'(acc) + diff;
        if (a > C_ACC_MAX)       a = C_ACC_MAX;
        else if (a < -C_ACC_MAX) a = -C_ACC_MAX;
        if (a > 0) begin
            r.out = 1'b1;
            r.acc = ACC_W'(a - 1);
        end else if (a < 0) begin
            r.out = 1'b1;
            r.sgn = 1'b1;
            r.acc = ACC_W'(a + 1);
        end
        return r;
    endfunction

    function automatic logic [LOG_LEN:0] est_sat(input logic signed [LOG_LEN:0] cnt);
        int v;
        v = int'(cnt);
        if (v > C_EST_LIM)       v = C_EST_LIM;
        else if (v < -C_EST_LIM) v = -C_EST_LIM;
        return (LOG_LEN + 1)'(v);
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_start;
    logic [LOG_LEN+1:0]        r_k;
    logic                      r_first;
    logic signed [LOG_LEN:0]   r_cnt;
    logic signed [LOG_LEN:0]   r_est;

    logic                      r_dn_out, r_dn_sgn;
    logic                      r_da_out, r_da_sgn;
    logic                      r_ds_out, r_ds_sgn;
    logic signed [ACC_W-1:0]   r_dn_acc, r_da_acc, r_ds_acc;
    int                        w_dn_diff, w_da_diff, w_ds_diff;
    add_t                      w_dn_res, w_da_res, w_ds_res;

    logic                      w_est_neg;
    logic [LOG_LEN:0]          w_est_mag;
    logic                      w_s_next;
    logic                      w_unused;

    assign w_unused = f;

    // ---------------- control ----------------
    always_ff @(posedge CLK) begin
        if (INIT) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        busy        = 1'b0;
        step_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (step_start) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_k == C_K_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                step_done   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT || w_start) r_k <= '0;
        else if (busy)       r_k <= r_k + (LOG_LEN + 2)'(1);
    end

    always_ff @(posedge CLK) begin
        if (INIT)         r_first <= 1'b0;
        else if (w_start) r_first <= step_first;
    end

    // ---------------- state-gradient regeneration ----------------
    assign w_est_neg = r_est[LOG_LEN];
    assign w_est_mag = w_est_neg ? -r_est : r_est;
    assign w_s_next  = !r_first && (w_est_mag > {1'b0, rnd});

    // ---------------- polar adders ----------------
    always_comb begin
        w_dn_diff = 0;
        for (int j = 0; j < NR; j++) begin
            w_dn_diff += polar_term(delta_c_next[j] & alpha_c_r[j], SIGN_delta_c_next[j] ^ SIGN_alpha_c_r[j]);
            w_dn_diff += polar_term(delta_f_next[j] & alpha_f_r[j], SIGN_delta_f_next[j] ^ SIGN_alpha_f_r[j]);
            w_dn_diff += polar_term(delta_i_next[j] & alpha_i_r[j], SIGN_delta_i_next[j] ^ SIGN_alpha_i_r[j]);
            w_dn_diff += polar_term(delta_o_next[j] & alpha_o_r[j], SIGN_delta_o_next[j] ^ SIGN_alpha_o_r[j]);
        end
        w_da_diff = polar_term(r_dn_out, r_dn_sgn);
        for (int j = 0; j < N; j++) begin
            w_da_diff += polar_term(delta_forwardLayer[j] & alpha[j], SIGN_delta_forwardLayer[j] ^ SIGN_alpha[j]);
        end
        w_ds_diff = polar_term(r_da_out & o & zp_c, r_da_sgn)
                  + polar_term(w_s_next & f_next, w_est_neg);
    end

    assign w_dn_res = polar_add(r_dn_acc, w_dn_diff);
    assign w_da_res = polar_add(r_da_acc, w_da_diff);
    assign w_ds_res = polar_add(r_ds_acc, w_ds_diff);

    always_ff @(posedge CLK) begin
        if (INIT || w_start) begin
            r_dn_out <= 1'b0;  r_dn_sgn <= 1'b0;  r_dn_acc <= '0;
            r_da_out <= 1'b0;  r_da_sgn <= 1'b0;  r_da_acc <= '0;
            r_ds_out <= 1'b0;  r_ds_sgn <= 1'b0;  r_ds_acc <= '0;
        end else begin
            r_dn_out <= w_dn_res.out;  r_dn_sgn <= w_dn_res.sgn;  r_dn_acc <= w_dn_res.acc;
            r_da_out <= w_da_res.out;  r_da_sgn <= w_da_res.sgn;  r_da_acc <= w_da_res.acc;
            r_ds_out <= w_ds_res.out;  r_ds_sgn <= w_ds_res.sgn;  r_ds_acc <= w_ds_res.acc;
        end
    end

    // ---------------- window count and estimate ----------------
    // The first three cycles only flush the adder pipeline and are not counted.
    always_ff @(posedge CLK) begin
        if (INIT || w_start) begin
            r_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            r_cnt <= '0;
        end else if (busy && (r_k >= C_K_FIRST) && (r_k <= C_K_LAST) && r_ds_out) begin
            if (!r_ds_sgn && (int'(r_cnt) != C_CNT_MAX))
                r_cnt <= r_cnt + (LOG_LEN + 1)'(1);
            else if (r_ds_sgn && (int'(r_cnt) != C_CNT_MIN))
                r_cnt <= r_cnt - (LOG_LEN + 1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT)                    r_est <= '0;
        else if (r_state == ST_DONE) r_est <= est_sat(r_cnt);
    end

    assign delta_state_est = r_est;

    // ---------------- gate outputs ----------------
    assign delta_f      = busy & r_ds_out & STATE_last & zp_f;
    assign delta_c      = busy & r_ds_out & i & zp_c;
    assign delta_i      = busy & r_ds_out & c & zp_i;
    assign delta_o      = busy & r_da_out & STATE_flat & zp_o;
    assign SIGN_delta_f = busy & r_ds_sgn;
    assign SIGN_delta_c = busy & r_ds_sgn;
    assign SIGN_delta_i = busy & r_ds_sgn;
    assign SIGN_delta_o = busy & r_da_sgn;

endmodule
`default_nettype wire

// File: tb/tb_nn_lstm_bptt_seq_polar.sv
`default_nettype none
//==============================================================================
// Module   : tb_nn_lstm_bptt_seq_polar
// Purpose  : Directed self-checking bench for nn_lstm_bptt_seq_polar (LOG_LEN=4).
// Revision : 1.0 - initial release
//==============================================================================
module tb_nn_lstm_bptt_seq_polar;

    localparam int N       = 3;
    localparam int NR      = 3;
    localparam int LOG_LEN = 4;
    localparam int ACC_W   = 4;
    localparam int CLIP    = 4;
    localparam int WIN     = (1 << LOG_LEN) + 3;

`ifdef NN_LSTM_BPTT_CLIP_EN
    localparam int EXP_SAT = 4;
`else
    localparam int EXP_SAT = 15;
`endif

    logic clk = 1'b0;
    logic INIT = 1'b1;
    logic step_start, step_first;
    logic [N-1:0]  delta_forwardLayer, SIGN_delta_forwardLayer, alpha, SIGN_alpha;
    logic [NR-1:0] delta_c_next, SIGN_delta_c_next, delta_f_next, SIGN_delta_f_next;
    logic [NR-1:0] delta_i_next, SIGN_delta_i_next, delta_o_next, SIGN_delta_o_next;
    logic [NR-1:0] alpha_c_r, SIGN_alpha_c_r, alpha_f_r, SIGN_alpha_f_r;
    logic [NR-1:0] alpha_i_r, SIGN_alpha_i_r, alpha_o_r, SIGN_alpha_o_r;
    logic f, i, c, o, f_next, STATE_last, STATE_flat, zp_f, zp_i, zp_o, zp_c;
    logic [LOG_LEN-1:0] rnd;
    logic delta_f, delta_i, delta_c, delta_o;
    logic SIGN_delta_f, SIGN_delta_i, SIGN_delta_c, SIGN_delta_o;
    logic busy, step_done;
    logic [LOG_LEN:0] delta_state_est;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nn_lstm_bptt_seq_polar #(
        .N(N), .NR(NR), .LOG_LEN(LOG_LEN), .ACC_W(ACC_W), .CLIP(CLIP)
    ) dut (
        .CLK(clk), .INIT(INIT), .step_start(step_start), .step_first(step_first),
        .delta_forwardLayer(delta_forwardLayer), .SIGN_delta_forwardLayer(SIGN_delta_forwardLayer),
        .alpha(alpha), .SIGN_alpha(SIGN_alpha),
        .delta_c_next(delta_c_next), .SIGN_delta_c_next(SIGN_delta_c_next),
        .delta_f_next(delta_f_next), .SIGN_delta_f_next(SIGN_delta_f_next),
        .delta_i_next(delta_i_next), .SIGN_delta_i_next(SIGN_delta_i_next),
        .delta_o_next(delta_o_next), .SIGN_delta_o_next(SIGN_delta_o_next),
        .alpha_c_r(alpha_c_r), .SIGN_alpha_c_r(SIGN_alpha_c_r),
        .alpha_f_r(alpha_f_r), .SIGN_alpha_f_r(SIGN_alpha_f_r),
        .alpha_i_r(alpha_i_r), .SIGN_alpha_i_r(SIGN_alpha_i_r),
        .alpha_o_r(alpha_o_r), .SIGN_alpha_o_r(SIGN_alpha_o_r),
        .f(f), .i(i), .c(c), .o(o), .f_next(f_next),
        .STATE_last(STATE_last), .STATE_flat(STATE_flat),
        .zp_f(zp_f), .zp_i(zp_i), .zp_o(zp_o), .zp_c(zp_c), .rnd(rnd),
        .delta_f(delta_f), .delta_i(delta_i), .delta_c(delta_c), .delta_o(delta_o),
        .SIGN_delta_f(SIGN_delta_f), .SIGN_delta_i(SIGN_delta_i),
        .SIGN_delta_c(SIGN_delta_c), .SIGN_delta_o(SIGN_delta_o),
        .busy(busy), .step_done(step_done), .delta_state_est(delta_state_est)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        step_start = 1'b0; step_first = 1'b0;
        delta_forwardLayer = '0; SIGN_delta_forwardLayer = '0; alpha = '0; SIGN_alpha = '0;
        delta_c_next = '0; SIGN_delta_c_next = '0; delta_f_next = '0; SIGN_delta_f_next = '0;
        delta_i_next = '0; SIGN_delta_i_next = '0; delta_o_next = '0; SIGN_delta_o_next = '0;
        alpha_c_r = '0; SIGN_alpha_c_r = '0; alpha_f_r = '0; SIGN_alpha_f_r = '0;
        alpha_i_r = '0; SIGN_alpha_i_r = '0; alpha_o_r = '0; SIGN_alpha_o_r = '0;
        f = 0; i = 0; c = 0; o = 0; f_next = 0; STATE_last = 0; STATE_flat = 0;
        zp_f = 0; zp_i = 0; zp_o = 0; zp_c = 0; rnd = '0;
    endtask

    // One positive forward product feeding delta_STATE, all gate taps open.
    task automatic set_pos_cfg();
        clear_inputs();
        o = 1; zp_c = 1; i = 1; c = 1; zp_i = 1; STATE_last = 1; zp_f = 1;
        STATE_flat = 1; zp_o = 1;
        delta_forwardLayer = 3'b001; alpha = 3'b001;
    endtask

    // Returns in the k=0 cycle of the new window.
    task automatic start_step(input logic first);
        step_first = first; step_start = 1'b1;
        tick();
        step_start = 1'b0; step_first = 1'b0;
    endtask

    task automatic run_to_done(input int k0, input bit drive_rnd, output int k_done);
        int k;
        k = k0;
        while (step_done !== 1'b1 && k < WIN + 20) begin
            if (drive_rnd) rnd = 4'(k % 15);
            tick();
            k++;
        end
        k_done = k;
    endtask

    task automatic test_reset();
        INIT = 1'b1;
        tick(); tick();
        INIT = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", step_done); end
        checks++; if (delta_state_est !== 5'd0) begin errors++; $display("FAIL reset_est: got %0d want 0", $signed(delta_state_est)); end
        checks++;
        if ({delta_f, delta_i, delta_c, delta_o, SIGN_delta_f, SIGN_delta_i, SIGN_delta_c, SIGN_delta_o} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %b want 00000000",
                {delta_f, delta_i, delta_c, delta_o, SIGN_delta_f, SIGN_delta_i, SIGN_delta_c, SIGN_delta_o});
        end
    endtask

    task automatic test_forward_pos();
        int kd;
        set_pos_cfg();
        start_step(1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy: got %b want 1", busy); end
        tick(); tick(); tick();
        checks++; if ({delta_f, delta_c, delta_i} !== 3'b111) begin errors++; $display("FAIL pos_gates_k3: got %b want 111", {delta_f, delta_c, delta_i}); end
        checks++; if ({SIGN_delta_f, SIGN_delta_c, SIGN_delta_i} !== 3'b000) begin errors++; $display("FAIL pos_signs_k3: got %b want 000", {SIGN_delta_f, SIGN_delta_c, SIGN_delta_i}); end
        run_to_done(3, 1'b0, kd);
        checks++; if (kd !== WIN) begin errors++; $display("FAIL pos_done_cycle: got %0d want %0d", kd, WIN); end
        checks++; if (delta_c !== 1'b0) begin errors++; $display("FAIL pos_gated_in_done: got %b want 0", delta_c); end
        tick();
        checks++; if (delta_state_est !== 5'(EXP_SAT)) begin errors++; $display("FAIL pos_est: got %0d want %0d", $signed(delta_state_est), EXP_SAT); end
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL pos_done_pulse: got %b want 0", step_done); end
    endtask

    task automatic test_init_mid();
        int kd;
        set_pos_cfg();
        start_step(1'b1);
        repeat (10) tick();
        checks++; if (delta_c !== 1'b1) begin errors++; $display("FAIL init_pre_active: got %b want 1", delta_c); end
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b want 0", busy); end
        checks++;
        if ({delta_f, delta_i, delta_c, delta_o, SIGN_delta_f, SIGN_delta_i, SIGN_delta_c, SIGN_delta_o} !== 8'h00) begin
            errors++; $display("FAIL init_outputs: got %b want 00000000",
                {delta_f, delta_i, delta_c, delta_o, SIGN_delta_f, SIGN_delta_i, SIGN_delta_c, SIGN_delta_o});
        end
        checks++; if (delta_state_est !== 5'd0) begin errors++; $display("FAIL init_est: got %0d want 0", $signed(delta_state_est)); end
        start_step(1'b1);
        run_to_done(0, 1'b0, kd);
        checks++; if (kd !== WIN) begin errors++; $display("FAIL init_rerun_cycle: got %0d want %0d", kd, WIN); end
        tick();
        checks++; if (delta_state_est !== 5'(EXP_SAT)) begin errors++; $display("FAIL init_rerun_est: got %0d want %0d", $signed(delta_state_est), EXP_SAT); end
    endtask

    task automatic test_forward_neg();
        int kd;
        set_pos_cfg();
        SIGN_alpha = 3'b001;
        start_step(1'b1);
        repeat (5) tick();
        checks++; if ({delta_f, delta_c, delta_i, delta_o} !== 4'b1111) begin errors++; $display("FAIL neg_gates: got %b want 1111", {delta_f, delta_c, delta_i, delta_o}); end
        checks++; if ({SIGN_delta_f, SIGN_delta_c, SIGN_delta_i, SIGN_delta_o} !== 4'b1111) begin errors++; $display("FAIL neg_signs: got %b want 1111", {SIGN_delta_f, SIGN_delta_c, SIGN_delta_i, SIGN_delta_o}); end
        run_to_done(5, 1'b0, kd);
        tick();
        checks++; if (delta_state_est !== 5'(-EXP_SAT)) begin errors++; $display("FAIL neg_est: got %0d want %0d", $signed(delta_state_est), -EXP_SAT); end
    endtask

    task automatic test_regen();
        int kd;
        set_pos_cfg();
        start_step(1'b1);
        run_to_done(0, 1'b0, kd);
        tick();
        checks++; if (delta_state_est !== 5'(EXP_SAT)) begin errors++; $display("FAIL regen_seed_est: got %0d want %0d", $signed(delta_state_est), EXP_SAT); end
        delta_forwardLayer = '0; alpha = '0; f_next = 1'b1;
        start_step(1'b0);
        for (int k = 0; k < 3; k++) begin
            rnd = 4'(k % 15);
            tick();
        end
        checks++; if ({delta_f, SIGN_delta_f} !== 2'b10) begin errors++; $display("FAIL regen_stream_k3: got %b want 10", {delta_f, SIGN_delta_f}); end
        run_to_done(3, 1'b1, kd);
        tick();
        checks++; if (delta_state_est !== 5'(EXP_SAT)) begin errors++; $display("FAIL regen_hold_est: got %0d want %0d", $signed(delta_state_est), EXP_SAT); end
        f_next = 1'b0;
        start_step(1'b0);
        run_to_done(0, 1'b1, kd);
        tick();
        checks++; if (delta_state_est !== 5'd0) begin errors++; $display("FAIL regen_fnext0_est: got %0d want 0", $signed(delta_state_est)); end
    endtask

    task automatic test_adder_balance();
        int kd;
        clear_inputs();
        STATE_flat = 1; zp_o = 1;
        delta_forwardLayer = 3'b111; alpha = 3'b111; SIGN_alpha = 3'b100;
        delta_c_next = 3'b001; alpha_c_r = 3'b001; SIGN_alpha_c_r = 3'b001;
        start_step(1'b1);
        checks++; if (delta_o !== 1'b0) begin errors++; $display("FAIL bal_k0: got %b want 0", delta_o); end
        tick();
        checks++; if ({delta_o, SIGN_delta_o} !== 2'b10) begin errors++; $display("FAIL bal_k1: got %b want 10", {delta_o, SIGN_delta_o}); end
        for (int k = 2; k <= 8; k++) begin
            tick();
            checks++; if (delta_o !== 1'b0) begin errors++; $display("FAIL bal_k%0d: got %b want 0", k, delta_o); end
        end
        run_to_done(8, 1'b0, kd);
        tick();
        checks++; if (delta_state_est !== 5'd0) begin errors++; $display("FAIL bal_est: got %0d want 0", $signed(delta_state_est)); end
    endtask

    task automatic test_adder_carry();
        int  kd;
        logic exp_o;
        clear_inputs();
        STATE_flat = 1; zp_o = 1;
        delta_forwardLayer = 3'b011; alpha = 3'b011;
        start_step(1'b1);
        for (int k = 0; k <= 8; k++) begin
            if (k == 3) begin delta_forwardLayer = '0; alpha = '0; end
            exp_o = (k >= 1 && k <= 6);
            checks++; if (delta_o !== exp_o) begin errors++; $display("FAIL carry_k%0d: got %b want %b", k, delta_o, exp_o); end
            tick();
        end
        run_to_done(9, 1'b0, kd);
        tick();
    endtask

    task automatic test_back_to_back();
        int kd;
        set_pos_cfg();
        start_step(1'b1);
        repeat (5) tick();
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        run_to_done(6, 1'b0, kd);
        checks++; if (kd !== WIN) begin errors++; $display("FAIL b2b_ignored_start: got %0d want %0d", kd, WIN); end
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done: got %b want 0", busy); end
        checks++; if (delta_state_est !== 5'(EXP_SAT)) begin errors++; $display("FAIL b2b_est: got %0d want %0d", $signed(delta_state_est), EXP_SAT); end
        start_step(1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        run_to_done(0, 1'b0, kd);
        checks++; if (kd !== WIN) begin errors++; $display("FAIL b2b_restart_cycle: got %0d want %0d", kd, WIN); end
        tick();
    endtask

    task automatic test_clip();
        int kd;
        set_pos_cfg();
        start_step(1'b1);
        run_to_done(0, 1'b0, kd);
        tick();
        checks++; if (delta_state_est !== 5'(EXP_SAT)) begin errors++; $display("FAIL clip_est: got %0d want %0d", $signed(delta_state_est), EXP_SAT); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forward_pos();
        test_init_mid();
        test_forward_neg();
        test_regen();
        test_adder_balance();
        test_adder_carry();
        test_back_to_back();
        test_clip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
